// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file, one write port, two registered read ports (1-cycle latency).
// Optional same-cycle write/clear bypass to the read ports and a hardwired-zero entry 0.
module reg_bank #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              ren_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             wr_ok;

  // clr wins over a simultaneous write; entry 0 is read-only when hardwired to zero
  assign wr_ok = we && !clr && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Later assignments override earlier ones, giving the read-select priority order
  always_comb begin
    sel_a = mem[raddr_a];
    if ((BYPASS != 0) && we && (waddr == raddr_a)) sel_a = wdata;
    if ((BYPASS != 0) && clr)                      sel_a = '0;
    if ((ZERO_REG != 0) && (raddr_a == '0))        sel_a = '0;
  end

  always_comb begin
    sel_b = mem[raddr_b];
    if ((BYPASS != 0) && we && (waddr == raddr_b)) sel_b = wdata;
    if ((BYPASS != 0) && clr)                      sel_b = '0;
    if ((ZERO_REG != 0) && (raddr_b == '0))        sel_b = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (ren_a) rdata_a <= sel_a;
      if (ren_b) rdata_b <= sel_b;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: three 8x8 variants (default, no bypass, zero reg) share one stimulus bus,
// a 16x32 variant gets random traffic; read results flow through per-port expectation queues.
module tb_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n, clr, we;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [7:0]  wdata;
  logic [3:0]  ren_a, ren_b;
  logic        clr3, we3;
  logic [3:0]  waddr3, raddr3_a, raddr3_b;
  logic [31:0] wdata3;

  logic [7:0]  d0a, d0b, d1a, d1b, d2a, d2b;
  logic [31:0] d3a, d3b;
  logic [31:0] rd_a [4];
  logic [31:0] rd_b [4];

  reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_d0 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a[0]), .raddr_a(raddr_a), .rdata_a(d0a),
    .ren_b(ren_b[0]), .raddr_b(raddr_b), .rdata_b(d0b));

  reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u_d1 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a[1]), .raddr_a(raddr_a), .rdata_a(d1a),
    .ren_b(ren_b[1]), .raddr_b(raddr_b), .rdata_b(d1b));

  reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_d2 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a[2]), .raddr_a(raddr_a), .rdata_a(d2a),
    .ren_b(ren_b[2]), .raddr_b(raddr_b), .rdata_b(d2b));

  reg_bank #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) u_d3 (
    .clk(clk), .clr_n(clr_n), .clr(clr3), .we(we3), .waddr(waddr3), .wdata(wdata3),
    .ren_a(ren_a[3]), .raddr_a(raddr3_a), .rdata_a(d3a),
    .ren_b(ren_b[3]), .raddr_b(raddr3_b), .rdata_b(d3b));

  always_comb begin
    rd_a[0] = {24'h0, d0a}; rd_b[0] = {24'h0, d0b};
    rd_a[1] = {24'h0, d1a}; rd_b[1] = {24'h0, d1b};
    rd_a[2] = {24'h0, d2a}; rd_b[2] = {24'h0, d2b};
    rd_a[3] = d3a;          rd_b[3] = d3b;
  end

  // A read issued at edge N presents its data from edge N: this is the output-valid
  logic [3:0] vld_a, vld_b;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_a <= '0;
      vld_b <= '0;
    end else begin
      vld_a <= ren_a;
      vld_b <= ren_b;
    end
  end

  typedef struct {
    int          dut;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic pop_check(input int k, input bit port_b, input logic [31:0] act);
    exp_t e;
    if ((port_b ? qb.size() : qa.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL underflow d%0d port_%s: got %h expected no read", k, port_b ? "b" : "a", act);
    end else begin
      e = port_b ? qb.pop_front() : qa.pop_front();
      if (e.dut != k) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s order: got read on d%0d expected d%0d", e.tag, k, e.dut);
      end else begin
        check($sformatf("%s d%0d port_%s", e.tag, k, port_b ? "b" : "a"), act, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (vld_a[k]) pop_check(k, 1'b0, rd_a[k]);
    for (int k = 0; k < 4; k++) if (vld_b[k]) pop_check(k, 1'b1, rd_b[k]);
  end

  task automatic idle();
    we = 1'b0; clr = 1'b0; ren_a = '0; ren_b = '0; we3 = 1'b0; clr3 = 1'b0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    go();
  endtask

  // Several DUTs reading in one cycle must be queued in ascending DUT order
  task automatic rda(input int k, input logic [2:0] a, input logic [31:0] e, input string tag);
    ren_a[k] = 1'b1; raddr_a = a;
    qa.push_back('{dut: k, val: e, tag: tag});
  endtask

  task automatic rdb(input int k, input logic [2:0] a, input logic [31:0] e, input string tag);
    ren_b[k] = 1'b1; raddr_b = a;
    qb.push_back('{dut: k, val: e, tag: tag});
  endtask

  logic [31:0] m3 [16];

  function automatic logic [31:0] pick3(input logic [3:0] a);
    if (clr3) return 32'h0;
    if (we3 && waddr3 == a) return wdata3;
    return m3[a];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0;
    idle();
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    waddr3 = '0; wdata3 = '0; raddr3_a = '0; raddr3_b = '0;
    for (int i = 0; i < 16; i++) m3[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_rdata_a d%0d", k), rd_a[k], 32'h0);
      check($sformatf("reset_rdata_b d%0d", k), rd_b[k], 32'h0);
    end
    clr_n = 1'b1;
    go();

    // write then read on both ports, then hold with ren low
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h5A);
    rda(0, 3'd3, 32'hA5, "wr_rd");
    rdb(0, 3'd7, 32'h5A, "wr_rd");
    go();
    go();
    go();
    check("hold_a", rd_a[0], 32'hA5);
    check("hold_b", rd_b[0], 32'h5A);

    // same-edge write/read: new data with bypass, old data without
    wr(3'd2, 8'h11);
    we = 1'b1; waddr = 3'd2; wdata = 8'h3C;
    rda(0, 3'd2, 32'h3C, "bypass_on");
    rda(1, 3'd2, 32'h11, "bypass_off");
    go();
    rda(1, 3'd2, 32'h3C, "bypass_off_late");
    go();

    // clear beats a simultaneous write
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    clr = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h77;
    rda(0, 3'd5, 32'h0, "clr_bypass");
    rda(1, 3'd5, 32'hFF, "clr_nobypass");
    go();
    for (int i = 0; i < 8; i++) begin
      rda(0, 3'(i), 32'h0, "clr_all");
      rdb(0, 3'(7 - i), 32'h0, "clr_all");
      go();
    end
    rda(1, 3'd5, 32'h0, "clr_drop_we");
    go();

    // hardwired zero entry
    wr(3'd0, 8'hFF);
    wr(3'd1, 8'hFF);
    rda(0, 3'd0, 32'hFF, "plain_e0");
    rda(2, 3'd0, 32'h0, "zero_reg_e0");
    rdb(2, 3'd1, 32'hFF, "zero_reg_e1");
    go();
    we = 1'b1; waddr = 3'd0; wdata = 8'hAB;
    rda(2, 3'd0, 32'h0, "zero_reg_bypass");
    rdb(0, 3'd0, 32'hAB, "plain_e0_bypass");
    go();

    // both ports on one address
    wr(3'd4, 8'h42);
    rda(0, 3'd4, 32'h42, "dual");
    rdb(0, 3'd4, 32'h42, "dual");
    go();
    we = 1'b1; waddr = 3'd4; wdata = 8'h99;
    rda(0, 3'd4, 32'h99, "dual_bypass");
    rdb(0, 3'd4, 32'h99, "dual_bypass");
    go();
    go();
    check("hold_dual", rd_a[0], 32'h99);

    // asynchronous reset mid-cycle with a write pending: outputs clear without a clock edge
    we = 1'b1; waddr = 3'd6; wdata = 8'hEE;
    #2;
    clr_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_rst_a d%0d", k), rd_a[k], 32'h0);
      check($sformatf("async_rst_b d%0d", k), rd_b[k], 32'h0);
    end
    @(posedge clk);
    #3;
    clr_n = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) begin
      rda(0, 3'(i), 32'h0, "post_rst");
      rdb(0, 3'(7 - i), 32'h0, "post_rst");
      go();
    end

    // 16x32 instance: random traffic against a reference array
    for (int n = 0; n < 400; n++) begin
      we3      = 1'($urandom_range(0, 1));
      waddr3   = 4'($urandom_range(0, 15));
      wdata3   = $urandom;
      clr3     = ($urandom_range(0, 24) == 0);
      raddr3_a = ($urandom_range(0, 3) == 0) ? waddr3 : 4'($urandom_range(0, 15));
      raddr3_b = ($urandom_range(0, 3) == 0) ? raddr3_a : 4'($urandom_range(0, 15));
      ren_a[3] = 1'($urandom_range(0, 1));
      ren_b[3] = 1'($urandom_range(0, 1));
      if (ren_a[3]) qa.push_back('{dut: 3, val: pick3(raddr3_a), tag: "rand"});
      if (ren_b[3]) qb.push_back('{dut: 3, val: pick3(raddr3_b), tag: "rand"});
      if (clr3) begin
        for (int i = 0; i < 16; i++) m3[i] = 32'h0;
      end else if (we3) begin
        m3[waddr3] = wdata3;
      end
      go();
    end

    go();
    go();
    check("drain_a", 32'(qa.size()), 32'h0);
    check("drain_b", 32'(qb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
